// File: rtl/step_sequencer_ctrl.sv
// Step-sequencer controller: N-step on/off pattern walked at a fixed tempo.
// Optional macro SEQ_CLEAR_ON_EXIT_EN clears the pattern when sequencer_on falls.
module step_sequencer_ctrl #(
    parameter int STEPS       = 8,
    parameter int STEP_CYCLES = 2500000,
    parameter int GATE_CYCLES = 1250000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STEPS-1:0]         toggle,
    input  logic                     sequencer_on,
    input  logic                     play,
    output logic [STEPS-1:0]         step_mask,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_tick,
    output logic                     gate,
    output logic                     running
);
    localparam int IW = $clog2(STEPS);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [31:0] GATE_LEN = GATE_CYCLES;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [STEPS-1:0] mask_q, mask_d;
    logic             run;

    assign run = sequencer_on & play;

`ifdef SEQ_CLEAR_ON_EXIT_EN
    logic son_q;

    always_ff @(posedge clk) begin
        if (rst) son_q <= 1'b0;
        else     son_q <= sequencer_on;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        if (sequencer_on) mask_d = mask_q ^ toggle;
`ifdef SEQ_CLEAR_ON_EXIT_EN
        if (son_q && !sequencer_on) mask_d = '0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (run) state_d = RUN;
            end
            RUN: begin
                if (!run) begin
                    // Stopping truncates the current step outright
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    assign running   = (state_q == RUN);
    assign step_tick = running & (cnt_q == '0);
    assign gate      = running & mask_q[idx_q] & (32'(cnt_q) < GATE_LEN);
    assign step_mask = mask_q;
    assign step_idx  = idx_q;
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Scoreboard bench for step_sequencer_ctrl: elapsed-time reference model
// feeds an expected-output queue drained by an independent monitor.
module tb_step_sequencer_ctrl;
    localparam int STEPS = 8;
    localparam int SC    = 4;
    localparam int GC    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] toggle;
    logic       sequencer_on;
    logic       play;
    logic [7:0] step_mask;
    logic [2:0] step_idx;
    logic       step_tick;
    logic       gate;
    logic       running;

    typedef struct packed {
        logic [7:0] mask;
        logic [2:0] idx;
        logic       tick;
        logic       gate;
        logic       run;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pattern, run flag, cycles elapsed since run start
    logic [7:0] m_mask = '0;
    logic       m_run  = 1'b0;
    int         m_t    = 0;
    logic       m_son  = 1'b0;

    step_sequencer_ctrl #(
        .STEPS(STEPS), .STEP_CYCLES(SC), .GATE_CYCLES(GC)
    ) dut (
        .clk(clk), .rst(rst), .toggle(toggle),
        .sequencer_on(sequencer_on), .play(play),
        .step_mask(step_mask), .step_idx(step_idx),
        .step_tick(step_tick), .gate(gate), .running(running)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic son,
                       input logic pl, input logic [7:0] tg);
        exp_t e;
        int   idx;
        @(negedge clk);
        rst = r; sequencer_on = son; play = pl; toggle = tg;
        if (r) begin
            m_mask = '0; m_run = 1'b0; m_t = 0; m_son = 1'b0;
        end else begin
            if (son) m_mask = m_mask ^ tg;
`ifdef SEQ_CLEAR_ON_EXIT_EN
            if (m_son && !son) m_mask = '0;
`endif
            m_son = son;
            if (son && pl) begin
                m_t   = m_run ? m_t + 1 : 0;
                m_run = 1'b1;
            end else begin
                m_run = 1'b0;
                m_t   = 0;
            end
        end
        idx    = m_run ? (m_t / SC) % STEPS : 0;
        e.mask = m_mask;
        e.idx  = 3'(idx);
        e.run  = m_run;
        e.tick = m_run && (m_t % SC == 0);
        e.gate = m_run && m_mask[idx] && (m_t % SC < GC);
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("step_mask", int'(step_mask), int'(e.mask));
            chk("step_idx",  int'(step_idx),  int'(e.idx));
            chk("step_tick", int'(step_tick), int'(e.tick));
            chk("gate",      int'(gate),      int'(e.gate));
            chk("running",   int'(running),   int'(e.run));
        end
    end

    initial begin
        rst = 1'b1; sequencer_on = 1'b1; play = 1'b1; toggle = '0;
        cyc(1, 1, 1, 8'h00);
        cyc(1, 1, 1, 8'h00);
        // pattern edit, then toggles ignored while sequencer off
        cyc(0, 1, 0, 8'h05);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h01);
        cyc(0, 0, 0, 8'hFF);
        cyc(0, 1, 0, 8'h01);
        cyc(0, 1, 0, 8'h00);
        // run past a full wrap; toggle step 2 at its cnt=0
        for (int k = 0; k < 44; k++)
            cyc(0, 1, 1, (k == 41) ? 8'h04 : 8'h00);
        cyc(0, 1, 1, 8'h00);
        cyc(0, 1, 1, 8'h00);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        for (int k = 0; k < 6; k++) cyc(0, 1, 1, 8'h00);
        // toggle together with stop
        cyc(0, 1, 0, 8'h02);
        // clear-on-exit behaviour
        cyc(0, 1, 0, m_mask ^ 8'h81);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        // reset mid-run
        cyc(0, 1, 1, 8'h3C);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 8'h00);
        cyc(1, 1, 1, 8'h00);
        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic r, son, pl;
            logic [7:0] tg;
            r   = ($urandom_range(0, 199) == 0);
            son = ($urandom_range(0, 19) != 0);
            pl  = ($urandom_range(0, 29) != 0) ? play : ~play;
            tg  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            cyc(r, son, pl, tg);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/step_sequencer_ctrl.md
Name: step_sequencer_ctrl

Overview:
- Step-sequencer controller for the synth keyboard front end.
- Consumes the one-cycle toggle pulses and the latched sequencer_on/play levels produced by the key encoder.
- Holds an N-step on/off pattern and walks a step pointer at a fixed tempo.
- Emits a per-step gate and a step tick that drive the oscillator/envelope path.

Parameters:
- STEPS, 8, number of steps; width of toggle, pattern and step_mask; power of two; ≥2.
- STEP_CYCLES, 2500000, clk cycles per step (tempo); ≥2.
- GATE_CYCLES, 1250000, cycles the gate stays high within an active step; 1 ≤ GATE_CYCLES ≤ STEP_CYCLES.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- toggle  input  STEPS  one-cycle pulses; bit i flips pattern bit i.
- sequencer_on  input  1  level; sequencer edit/run enable.
- play  input  1  level; transport run.
- step_mask  output  STEPS  current pattern register.
- step_idx  output  $clog2(STEPS)  current step pointer.
- step_tick  output  1  one-cycle pulse at the start of each step while running.
- gate  output  1  note gate for the current step.
- running  output  1  high while FSM is in RUN.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high; sampled only on the clk rising edge.
  - While rst=1, every register loads its reset value on each edge.
- Reset values:
  - step_mask=0, step_idx=0, cycle counter cnt=0, state=IDLE.
  - Therefore step_tick=0, gate=0, running=0.
- Pattern register:
  - In any cycle with sequencer_on=1 and toggle[i]=1, step_mask[i] inverts at the next edge.
  - Multiple bits in one cycle all invert.
  - toggle is ignored when sequencer_on=0.
  - Pattern is retained across stop/start (see Optional Feature).
- run = sequencer_on & play (combinational).
- FSM states and transitions:
  - IDLE, run=1 → RUN. At the same edge: cnt←0, step_idx←0.
  - IDLE, run=0 → stay IDLE. step_idx and cnt hold 0.
  - RUN, run=0 → IDLE. At the same edge: cnt←0, step_idx←0. Stopping mid-step truncates that step; no tail.
  - RUN, run=1, cnt=STEP_CYCLES-1 → cnt←0, step_idx←(step_idx+1) mod STEPS (wraps STEPS-1→0).
  - RUN, run=1, otherwise → cnt←cnt+1.
- Outputs (decoded from registers only, so glitch-free):
  - running = (state==RUN).
  - step_tick = running & (cnt==0).
  - gate = running & step_mask[step_idx] & (cnt < GATE_CYCLES).
- Latency:
  - run rising in cycle N → running, step_tick=1 and step 0 gate in cycle N+1.
  - run falling in cycle N → running=0, gate=0 in cycle N+1.
- Simultaneous events:
  - A toggle of the current step takes effect on gate the cycle after the pulse, even mid-step.
  - The gate then rises or falls immediately if cnt < GATE_CYCLES.
  - Toggle together with a run/stop transition: both apply at the same edge.
- Gate shape: with GATE_CYCLES=STEP_CYCLES, consecutive active steps give a continuous gate with no gap.
- rst mid-RUN: next edge → IDLE with all reset values, including the pattern.
- cnt width: $clog2(STEP_CYCLES); must never exceed STEP_CYCLES-1.

Optional Feature:
- Macro: SEQ_CLEAR_ON_EXIT_EN.
- Defined:
  - A registered copy of sequencer_on detects its falling edge.
  - In the cycle after the 1→0 transition is seen, step_mask←0.
  - Toggles in that cycle are ignored anyway, since sequencer_on=0.
- Undefined:
  - step_mask is cleared only by rst.
  - No extra register is built.

Test Plan:
- Use STEPS=8, STEP_CYCLES=4, GATE_CYCLES=2 throughout.
- Reset: hold rst=1 for 2 cycles with play=1, sequencer_on=1 → step_mask=0x00, step_idx=0, gate=0, running=0.
- Pattern edit: sequencer_on=1, play=0; pulse toggle=0x05, then toggle=0x01 → step_mask=0x05, then 0x04. With sequencer_on=0, toggle=0xFF → step_mask unchanged.
- Run timing:
  - step_mask=0x05; raise play at cycle N → running=1 and step_tick at N+1, N+5, N+9.
  - step_idx 0,1,2 on those ticks.
  - gate high at N+1..N+2 and N+9..N+10; low during step 1.
- Wrap: let the sequence run 8 steps → step_idx goes 7→0 at cycle N+33 with step_tick=1.
- Stop and mid-step toggle:
  - Pulse toggle[2] during step 2 at cnt=0 → gate falls the next cycle.
  - Drop play at cnt=1 of a later step → running=0, gate=0, step_idx=0 next cycle.
  - Restart play → step 0 begins one cycle later.
- Optional feature, macro defined: step_mask=0x81, drop sequencer_on → step_mask=0x00 within 2 cycles. Macro undefined → stays 0x81.
